// File: rtl/display_scan_ctrl_if.sv
// Load handshake between a value source and the display scan controller.
interface display_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] data_in;
    logic        lzb;

    // Source side: offers a value and waits for ready.
    modport master (
        output load_valid,
        output data_in,
        output lzb,
        input  load_ready
    );

    // Controller side: accepts the value when ready.
    modport slave (
        input  load_valid,
        input  data_in,
        input  lzb,
        output load_ready
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with tear-free loading,
// ghost guard at the start of every digit slot and leading-zero blanking.
module display_scan_ctrl #(
    parameter int PRESCALE = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_clear,
    display_scan_ctrl_if.slave          load_if,
    output logic [3:0]                  o_nibble,
    output logic [3:0]                  o_digit_en,
    output logic                        o_blank,
    output logic                        o_frame_done
);

    localparam logic [0:0]  ST_OFF    = 1'b0;
    localparam logic [0:0]  ST_SCAN   = 1'b1;
    localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

    logic [0:0]  r_state;
    logic [15:0] r_value;
    logic        r_lzb_q;
    logic [1:0]  r_idx;
    logic [15:0] r_pcnt;

    logic        w_frame_end;
    logic        w_ready;
    logic        w_xfer;

    // Leading-zero blanking: digit idx is dark when it and every digit to
    // its left are zero. The rightmost digit always shows.
    function automatic logic lzb_blank(input logic [15:0] value,
                                       input logic        lzb_q,
                                       input logic [1:0]  idx);
        logic res;
        case (idx)
            2'd0:    res = 1'b0;
            2'd1:    res = lzb_q & (value[15:4]  == 12'h000);
            2'd2:    res = lzb_q & (value[15:8]  == 8'h00);
            2'd3:    res = lzb_q & (value[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Last cycle of digit 3: the only point where a new value may enter
    // while scanning, so a frame never mixes old and new nibbles.
    always_comb begin
        w_frame_end = 1'b0;
        if ((r_state == ST_SCAN) && (r_idx == 2'd3) && (r_pcnt == PCNT_LAST)) begin
            w_frame_end = 1'b1;
        end else begin
            w_frame_end = 1'b0;
        end
    end

    // Ready when idle or at the frame wrap; reset and clear suppress it.
    always_comb begin
        w_ready = 1'b0;
        if (i_rst || i_clear) begin
            w_ready = 1'b0;
        end else if (r_state == ST_OFF) begin
            w_ready = 1'b1;
        end else begin
            w_ready = w_frame_end;
        end
    end

    assign w_xfer            = load_if.load_valid & w_ready;
    assign load_if.load_ready = w_ready;

    // Controller state: reset, clear, value capture and slot/digit counting.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_OFF;
            r_value <= 16'h0000;
            r_lzb_q <= 1'b0;
            r_idx   <= 2'd0;
            r_pcnt  <= 16'd0;
        end else if (i_clear) begin
            r_state <= ST_OFF;
            r_idx   <= 2'd0;
            r_pcnt  <= 16'd0;
        end else begin
            if (w_xfer) begin
                r_value <= load_if.data_in;
                r_lzb_q <= load_if.lzb;
            end else begin
                r_value <= r_value;
                r_lzb_q <= r_lzb_q;
            end
            case (r_state)
                ST_OFF: begin
                    if (w_xfer) begin
                        r_state <= ST_SCAN;
                    end else begin
                        r_state <= ST_OFF;
                    end
                    r_idx  <= 2'd0;
                    r_pcnt <= 16'd0;
                end
                ST_SCAN: begin
                    // A transfer here happens at idx 3 / last count, so the
                    // natural wrap lands on idx 0, pcnt 0 for the new value.
                    r_state <= ST_SCAN;
                    if (r_pcnt == PCNT_LAST) begin
                        r_pcnt <= 16'd0;
                        r_idx  <= r_idx + 2'd1;
                    end else begin
                        r_pcnt <= r_pcnt + 16'd1;
                        r_idx  <= r_idx;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_idx   <= 2'd0;
                    r_pcnt  <= 16'd0;
                end
            endcase
        end
    end

    // Nibble for the shared decoder: the current digit while scanning.
    always_comb begin
        o_nibble = 4'h0;
        if (r_state == ST_SCAN) begin
            case (r_idx)
                2'd0:    o_nibble = r_value[3:0];
                2'd1:    o_nibble = r_value[7:4];
                2'd2:    o_nibble = r_value[11:8];
                2'd3:    o_nibble = r_value[15:12];
                default: o_nibble = 4'h0;
            endcase
        end else begin
            o_nibble = 4'h0;
        end
    end

    // Active-low digit select; dark on the first cycle of each slot so the
    // previous digit's segments cannot ghost onto the next one.
    always_comb begin
        o_digit_en = 4'b1111;
        if ((r_state == ST_SCAN) && (r_pcnt != 16'd0)) begin
            case (r_idx)
                2'd0:    o_digit_en = 4'b1110;
                2'd1:    o_digit_en = 4'b1101;
                2'd2:    o_digit_en = 4'b1011;
                2'd3:    o_digit_en = 4'b0111;
                default: o_digit_en = 4'b1111;
            endcase
        end else begin
            o_digit_en = 4'b1111;
        end
    end

    // Segment blanking: idle, ghost-guard cycle, or suppressed leading zero.
    always_comb begin
        o_blank = 1'b1;
        if (r_state != ST_SCAN) begin
            o_blank = 1'b1;
        end else if (r_pcnt == 16'd0) begin
            o_blank = 1'b1;
        end else begin
            o_blank = lzb_blank(r_value, r_lzb_q, r_idx);
        end
    end

    assign o_frame_done = w_frame_end;

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter: PRESCALE, 4, clock cycles per digit slot; legal range 2..65535.
REQ-002 Port: Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clock.
REQ-004 Port: CLEAR  input  1  synchronous request to stop scanning and return to OFF.
REQ-005 Port: LOAD_VALID  input  1  new display value offered.
REQ-006 Port: LOAD_READY  output  1  controller accepts the value this cycle.
REQ-007 Port: DATA_IN  input  16  four hex nibbles; [3:0] is digit 0, the rightmost digit.
REQ-008 Port: LZB  input  1  leading-zero blanking enable, captured with DATA_IN.
REQ-009 Port: NIBBLE  output  4  code for the shared external 7-segment hex decoder.
REQ-010 Port: DIGIT_EN  output  4  active-low one-hot digit select; 4'b1111 means no digit selected.
REQ-011 Port: BLANK  output  1  high forces the shared decoder's segment outputs off.
REQ-012 Port: FRAME_DONE  output  1  one-cycle pulse on the last cycle of digit 3.

Function
REQ-013 State machine SHALL have two states: OFF and SCAN.
REQ-014 Internal registers SHALL be: VALUE[15:0], LZB_Q, digit index IDX[1:0], and prescaler PCNT[15:0].
REQ-015 PCNT SHALL count 0..PRESCALE-1 in SCAN; at PRESCALE-1 it wraps to 0 and IDX advances 0->1->2->3->0.
REQ-016 LOAD_READY SHALL be combinational and equal 1 when state is OFF, or when state is SCAN with IDX=3 and PCNT=PRESCALE-1; LOAD_READY SHALL be forced to 0 whenever CLEAR=1 or Reset=1.
REQ-017 A transfer SHALL occur on a rising edge with LOAD_VALID=1 and LOAD_READY=1: VALUE<=DATA_IN, LZB_Q<=LZB.
REQ-018 A transfer in OFF SHALL move the state to SCAN with IDX=0 and PCNT=0 on the next cycle.
REQ-019 A transfer in SCAN SHALL coincide with the frame wrap, so the new VALUE is first shown at IDX=0, PCNT=0; the display SHALL never show a mix of old and new nibbles within a frame.
REQ-020 If LOAD_VALID is high while LOAD_READY=0, the source SHALL hold; the controller SHALL take no action and drop no data.
REQ-021 NIBBLE SHALL equal VALUE[4*IDX+3 : 4*IDX] in SCAN, and 4'h0 in OFF.
REQ-022 Ghost guard: in SCAN with PCNT=0, DIGIT_EN SHALL be 4'b1111 and BLANK=1; with PCNT>=1, DIGIT_EN SHALL be the active-low one-hot of IDX.
REQ-023 Digit IDX=i with i in 1..3 SHALL be blanked (BLANK=1, DIGIT_EN unchanged) when LZB_Q=1 and nibbles i..3 of VALUE are all zero; digit 0 SHALL never be blanked by LZB.
REQ-024 In OFF: DIGIT_EN=4'b1111, BLANK=1, FRAME_DONE=0.
REQ-025 FRAME_DONE SHALL be 1 exactly when state is SCAN, IDX=3 and PCNT=PRESCALE-1.
REQ-026 CLEAR=1 on a rising edge SHALL move the state to OFF, zero IDX and PCNT, and retain VALUE; CLEAR SHALL win over a simultaneous LOAD_VALID, and no transfer occurs.
REQ-027 NIBBLE, DIGIT_EN, BLANK, LOAD_READY and FRAME_DONE SHALL be combinational functions of the registers, plus CLEAR and Reset for LOAD_READY; there SHALL be no extra output latency.

Reset
REQ-028 Reset=1 on a rising edge SHALL set state=OFF, VALUE=16'h0000, LZB_Q=0, IDX=0 and PCNT=0, with priority over CLEAR and any transfer.
REQ-029 From the first edge after reset: DIGIT_EN=4'b1111, BLANK=1, NIBBLE=4'h0, FRAME_DONE=0; LOAD_READY=1 once Reset=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately, with no FRAME_DONE pulse.

Verification
REQ-031 First load (PRESCALE=4): after reset, present DATA_IN=16'h12AF with LZB=0 for one cycle -> transfer, then SCAN. Per 4-cycle slot: cycle 0 DIGIT_EN=1111, BLANK=1; cycles 1-3 DIGIT_EN=1110/1101/1011/0111 with NIBBLE=F/A/2/1. FRAME_DONE pulses on cycle 16.
REQ-032 Leading-zero blanking: load 16'h0007 with LZB=1 -> digit 0 shows NIBBLE=7, BLANK=0; digits 1-3 have BLANK=1. With LZB=0, all four digits are unblanked and show 0,0,0 on digits 1-3.
REQ-033 Tear-free update: while scanning 16'h1111, hold LOAD_VALID=1 with 16'h2222 starting at IDX=1 -> LOAD_READY stays 0 until IDX=3, PCNT=3. The transfer happens in the FRAME_DONE cycle, and the next frame shows only 2s.
REQ-034 CLEAR versus load: assert CLEAR and LOAD_VALID together in the FRAME_DONE cycle -> state OFF, no transfer, VALUE unchanged. A later load resumes scanning at IDX=0.
REQ-035 Reset mid-operation: assert Reset at IDX=2, PCNT=2 -> next cycle OFF, outputs at reset values, VALUE=0, no FRAME_DONE.
REQ-036 Minimum prescale: with PRESCALE=2, each digit is enabled exactly 1 cycle per slot, and a frame lasts 8 cycles.
